// File: rtl/mac_tx_framer_pkg.sv
// Shared types and constants for the MAC TX dibit framer.
// Optional padding is controlled by the MAC_TX_PAD_EN macro.
package mac_tx_framer_pkg;

  localparam int unsigned MAC_W              = 48;
  localparam int unsigned TYPE_W             = 16;
  localparam int unsigned DIBIT_W            = 2;
  localparam int unsigned MAC_DIBITS         = 24;
  localparam int unsigned TYPE_DIBITS        = 8;
  localparam int unsigned MIN_PAYLOAD_DIBITS = 184;
  localparam int unsigned CNT_W              = 10;
  localparam int unsigned CNT_MAX            = (1 << CNT_W) - 1;
  localparam int unsigned FCNT_W             = 5;

`ifdef MAC_TX_PAD_EN
  typedef enum logic [2:0] {IDLE, DEST, SRC, TYPE, DATA, PAD} state_e;
`else
  typedef enum logic [2:0] {IDLE, DEST, SRC, TYPE, DATA} state_e;
`endif

  // Places the type field in the top bits so the 48-bit shifter can emit it.
  function automatic logic [MAC_W-1:0] type_left_align(input logic [TYPE_W-1:0] t);
    return {t, (MAC_W - TYPE_W)'(0)};
  endfunction

endpackage

// File: rtl/mac_tx_framer_if.sv
// Source/sink handshake bundle for the MAC TX framer.
interface mac_tx_framer_if;
  import mac_tx_framer_pkg::*;

  logic               start;
  logic               axiiv;
  logic [DIBIT_W-1:0] axiid;
  logic               axiir;
  logic               axiov;
  logic [DIBIT_W-1:0] axiod;
  logic               busy;
  logic               done;

  modport master (
    output start, axiiv, axiid,
    input  axiir, axiov, axiod, busy, done
  );

  modport slave (
    input  start, axiiv, axiid,
    output axiir, axiov, axiod, busy, done
  );

endinterface

// File: rtl/mac_tx_field_shifter.sv
// Loads a 48-bit field and presents it MSB-first, one dibit per shift.
module mac_tx_field_shifter
  import mac_tx_framer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [MAC_W-1:0]   load_val_i,
  output logic [DIBIT_W-1:0] dibit_c
);

  logic [MAC_W-1:0] sh_q;
  logic [MAC_W-1:0] sh_d;

  // On load the first dibit comes straight from the input so it can be used the same cycle.
  always_comb begin
    sh_d    = sh_q;
    dibit_c = sh_q[MAC_W-1 -: DIBIT_W];
    if (load_i) begin
      sh_d    = load_val_i << DIBIT_W;
      dibit_c = load_val_i[MAC_W-1 -: DIBIT_W];
    end else if (shift_i) begin
      sh_d = sh_q << DIBIT_W;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

endmodule

// File: rtl/mac_tx_framer.sv
// Ethernet-style TX framer: dest MAC, src MAC, ethertype, payload, optional pad.
// Define MAC_TX_PAD_EN to pad short payloads with zero dibits to the minimum length.
module mac_tx_framer
  import mac_tx_framer_pkg::*;
#(
  parameter logic [MAC_W-1:0]  FPGA_MAC  = '0,
  parameter logic [MAC_W-1:0]  HOST_MAC  = '0,
  parameter logic [TYPE_W-1:0] ETHERTYPE = '0
)
(
  input logic           clk,
  input logic           rst,
  mac_tx_framer_if.slave bus
);

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                axiov_q, axiov_d;
  logic [DIBIT_W-1:0]  axiod_q, axiod_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                sh_load;
  logic                sh_shift;
  logic [MAC_W-1:0]    sh_val;
  logic [DIBIT_W-1:0]  sh_dibit;

  mac_tx_field_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sh_load),
    .shift_i    (sh_shift),
    .load_val_i (sh_val),
    .dibit_c    (sh_dibit)
  );

  // state_q names the field whose dibit is emitted at the coming edge,
  // so DATA is entered while the last type dibit is still on the output.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    cnt_d    = cnt_q;
    axiov_d  = 1'b0;
    axiod_d  = '0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_val   = '0;

    case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          sh_load = 1'b1;
          sh_val  = HOST_MAC;
          axiov_d = 1'b1;
          axiod_d = sh_dibit;
          fcnt_d  = FCNT_W'(1);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = DEST;
        end
      end

      DEST: begin
        sh_shift = 1'b1;
        axiov_d  = 1'b1;
        axiod_d  = sh_dibit;
        if (fcnt_q == FCNT_W'(MAC_DIBITS - 1)) begin
          fcnt_d  = '0;
          state_d = SRC;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end

      SRC: begin
        sh_val   = FPGA_MAC;
        sh_load  = (fcnt_q == '0);
        sh_shift = (fcnt_q != '0);
        axiov_d  = 1'b1;
        axiod_d  = sh_dibit;
        if (fcnt_q == FCNT_W'(MAC_DIBITS - 1)) begin
          fcnt_d  = '0;
          state_d = TYPE;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end

      TYPE: begin
        sh_val   = type_left_align(ETHERTYPE);
        sh_load  = (fcnt_q == '0);
        sh_shift = (fcnt_q != '0);
        axiov_d  = 1'b1;
        axiod_d  = sh_dibit;
        if (fcnt_q == FCNT_W'(TYPE_DIBITS - 1)) begin
          fcnt_d  = '0;
          state_d = DATA;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end

      // Any edge without a valid dibit ends the payload.
      DATA: begin
        if (bus.axiiv) begin
          axiov_d = 1'b1;
          axiod_d = bus.axiid;
          if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        end
`ifdef MAC_TX_PAD_EN
        else if (cnt_q < CNT_W'(MIN_PAYLOAD_DIBITS)) begin
          axiov_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = PAD;
        end
`endif
        else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

`ifdef MAC_TX_PAD_EN
      PAD: begin
        if (cnt_q < CNT_W'(MIN_PAYLOAD_DIBITS)) begin
          axiov_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
`endif

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      cnt_q   <= '0;
      axiov_q <= 1'b0;
      axiod_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.axiir = (state_q == DATA);
  assign bus.axiov = axiov_q;
  assign bus.axiod = axiod_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer: frame-level model of header/payload/pad, checked every cycle.
module tb_mac_tx_framer;

  localparam logic [47:0] HOST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] FPGA = 48'h123456789ABC;
  localparam logic [15:0] ET   = 16'h88B5;
`ifdef MAC_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_tx_framer_if bus ();

  mac_tx_framer #(.FPGA_MAC(FPGA), .HOST_MAC(HOST), .ETHERTYPE(ET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] stg_q[$];
  logic [2:0] src_q[$];   // {valid, dibit}
  bit  active = 1'b0;
  bit  rdy_prev = 1'b0;
  int  rdy_cnt = 0, last_rdy = 0, frames = 0, cyc = 0, start_cyc = 0, last_lat = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Payload source: pops an entry once the DUT has sampled it with axiir high.
  initial begin
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    forever begin
      @(negedge clk);
      if (rdy_prev && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && src_q[0][2]) begin
        bus.axiiv = 1'b1;
        bus.axiid = src_q[0][1:0];
      end else begin
        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
      end
      rdy_prev = bus.axiir;
    end
  end

  // Per-cycle compare against the expected frame stream.
  initial forever begin
    @(negedge clk);
    if (active && exp_q.size() > 0) begin
      chk("axiov", 32'(bus.axiov), 32'd1);
      chk("axiod", 32'(bus.axiod), 32'(exp_q[0]));
      chk("busy",  32'(bus.busy),  32'd1);
      chk("done",  32'(bus.done),  32'd0);
      if (bus.axiir) rdy_cnt++;
      void'(exp_q.pop_front());
    end else if (active) begin
      chk("end_axiov", 32'(bus.axiov), 32'd0);
      chk("end_axiod", 32'(bus.axiod), 32'd0);
      chk("end_busy",  32'(bus.busy),  32'd0);
      chk("end_done",  32'(bus.done),  32'd1);
      chk("end_axiir", 32'(bus.axiir), 32'd0);
      last_rdy = rdy_cnt;
      last_lat = cyc - start_cyc;
      frames++;
      active = 1'b0;
    end else begin
      chk("idle_axiov", 32'(bus.axiov), 32'd0);
      chk("idle_axiod", 32'(bus.axiod), 32'd0);
      chk("idle_busy",  32'(bus.busy),  32'd0);
      chk("idle_done",  32'(bus.done),  32'd0);
      chk("idle_axiir", 32'(bus.axiir), 32'd0);
    end
  end

  // Expected frame: header fields MSB-first, payload up to the first gap, zero pad.
  task automatic build_exp();
    logic [47:0] h, f;
    logic [15:0] t;
    int n;
    bit stop;
    h = HOST; f = FPGA; t = ET;
    stg_q.delete();
    for (int k = 0; k < 24; k++) stg_q.push_back({h[47-2*k], h[46-2*k]});
    for (int k = 0; k < 24; k++) stg_q.push_back({f[47-2*k], f[46-2*k]});
    for (int k = 0; k < 8; k++)  stg_q.push_back({t[15-2*k], t[14-2*k]});
    n = 0;
    stop = 1'b0;
    foreach (src_q[i]) begin
      if (!stop) begin
        if (src_q[i][2]) begin
          stg_q.push_back(src_q[i][1:0]);
          n++;
        end else begin
          stop = 1'b1;
        end
      end
    end
    if (PAD_ON) begin
      while (n < 184) begin
        stg_q.push_back(2'b00);
        n++;
      end
    end
  endtask

  task automatic load_bits(input logic [63:0] v, input int n);
    src_q.delete();
    for (int k = 0; k < n; k++) src_q.push_back({1'b1, v[2*n-1-2*k], v[2*n-2-2*k]});
  endtask

  task automatic launch();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    exp_q = stg_q;
    rdy_cnt = 0;
    start_cyc = cyc;
    active = 1'b1;
  endtask

  task automatic wait_frame(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (!active) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout got=active want=idle t=%0t", nm, $time);
      active = 1'b0;
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_axiov", 32'(bus.axiov), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_axiir", 32'(bus.axiir), 32'd0);

    // DEADBEEF frame with literal pins on the model
    load_bits(64'hDEADBEEF, 16);
    build_exp();
    chk("m_len",  32'(stg_q.size()), PAD_ON ? 32'd240 : 32'd72);
    chk("m_d0",   32'(stg_q[0]),  32'd3);
    chk("m_d24",  32'(stg_q[24]), 32'd0);
    chk("m_d25",  32'(stg_q[25]), 32'd1);
    chk("m_d27",  32'(stg_q[27]), 32'd2);
    chk("m_d48",  32'(stg_q[48]), 32'd2);
    chk("m_d53",  32'(stg_q[53]), 32'd3);
    chk("m_d55",  32'(stg_q[55]), 32'd1);
    chk("m_d56",  32'(stg_q[56]), 32'd3);
    chk("m_d57",  32'(stg_q[57]), 32'd1);
    chk("m_d59",  32'(stg_q[59]), 32'd2);
    launch();
    wait_frame("deadbeef");
    chk("deadbeef_lat", 32'(last_lat), PAD_ON ? 32'd240 : 32'd72);
    chk("deadbeef_rdy", 32'(last_rdy), 32'd17);

    // 200-dibit payload: no padding, axiir for payload plus terminating cycle
    src_q.delete();
    for (int i = 0; i < 200; i++) src_q.push_back({1'b1, 2'(i * 3 + (i >> 2))});
    build_exp();
    chk("m_len200", 32'(stg_q.size()), 32'd256);
    launch();
    wait_frame("p200");
    chk("p200_rdy", 32'(last_rdy), 32'd201);
    chk("p200_lat", 32'(last_lat), 32'd256);

    // Reset during header dibit 30, then a clean frame
    load_bits(64'hDEADBEEF, 16);
    build_exp();
    launch();
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    active = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_axiov", 32'(bus.axiov), 32'd0);
    chk("mid_rst_axiod", 32'(bus.axiod), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy),  32'd0);
    chk("mid_rst_axiir", 32'(bus.axiir), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    src_q.delete();
    load_bits(64'hDEADBEEF, 16);
    build_exp();
    launch();
    wait_frame("after_rst");
    chk("after_rst_lat", 32'(last_lat), PAD_ON ? 32'd240 : 32'd72);

    // start during DATA and coincident with done is ignored; one cycle later starts a frame
    load_bits(64'h0123456789, 20);
    build_exp();
    launch();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (bus.axiir) seen = 1'b1;
      end
      chk("data_reached", 32'(seen), 32'd1);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge clk);
        if (bus.done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("ign_axiov", 32'(bus.axiov), 32'd0);
      chk("ign_busy",  32'(bus.busy),  32'd0);
    end
    load_bits(64'hABC, 6);
    build_exp();
    launch();
    wait_frame("restart");
    chk("restart_rdy", 32'(last_rdy), 32'd7);

    // Bubble after 10 payload dibits ends the payload
    load_bits(64'hF0F0F, 10);
    src_q.push_back(3'b000);
    for (int i = 0; i < 10; i++) src_q.push_back(3'b111);
    build_exp();
    chk("m_len_bubble", 32'(stg_q.size()), PAD_ON ? 32'd240 : 32'd66);
    launch();
    wait_frame("bubble");
    chk("bubble_rdy", 32'(last_rdy), 32'd11);
    src_q.delete();

    // Zero-length payload
    build_exp();
    chk("m_len_zero", 32'(stg_q.size()), PAD_ON ? 32'd240 : 32'd56);
    launch();
    wait_frame("zero");
    chk("zero_rdy", 32'(last_rdy), 32'd1);

    repeat (3) @(negedge clk);
    chk("frames", 32'(frames), 32'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

endmodule
